// File: rtl/sap_ext_mem_bridge.sv
// sap_ext_mem_bridge: sequences one core memory request onto multiplexed IO pads.
// A transaction runs through address beats (with pin_ale high), optional wait states,
// then data beats that either drive write data or sample pin_in. Every beat moves the
// most-significant slice first.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in idle)
//   req_we/req_addr/req_wdata   request fields, latched when the request is accepted
//   rsp_valid                   one-cycle completion pulse, for reads and writes
//   rsp_rdata                   data from the last completed read
//   busy                        high while a transaction is in flight
//   pin_out/pin_oe/pin_in       pad data out, output enable, pad data in
//   pin_ale/pin_we/pin_re       address-latch, write and read strobes
module sap_ext_mem_bridge #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  input  logic [PIN_W-1:0]  pin_in,
  output logic              pin_ale,
  output logic              pin_we,
  output logic              pin_re
);

  localparam int unsigned ADDR_BEATS = ADDR_W / PIN_W;
  localparam int unsigned DATA_BEATS = DATA_W / PIN_W;
  localparam int unsigned MAX_AD     = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
  localparam int unsigned MAX_CNT    = (MAX_AD > WAIT_CYCLES) ? MAX_AD : WAIT_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BEATS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  if ((PIN_W == 0) || (ADDR_W == 0) || (DATA_W == 0) || ((ADDR_W % PIN_W) != 0) ||
      ((DATA_W % PIN_W) != 0) || (WAIT_CYCLES > 15)) begin : g_bad_param
    $error("sap_ext_mem_bridge: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] cap_shift;

  logic [PIN_W-1:0]  pin_out_q, pin_out_d;
  logic [PIN_W-1:0]  pin_oe_q, pin_oe_d;
  logic              pin_ale_q, pin_ale_d;
  logic              pin_we_q, pin_we_d;
  logic              pin_re_q, pin_re_d;
  logic              rsp_valid_q, rsp_valid_d;

  int unsigned       addr_shamt, data_shamt;

  // Next state, counter and latched request fields.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cap_d     = cap_q;
    rdata_d   = rdata_q;
    // Newest pad sample enters at the bottom, so the first beat ends up most significant.
    cap_shift = DATA_W'({cap_q, pin_in});

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StAddr;
          cnt_d   = '0;
          wr_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      StAddr: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? StData : StWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWait: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (!wr_q) begin
          cap_d = cap_shift;
        end
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = StDone;
          // Includes the sample taken on this same edge.
          if (!wr_q) begin
            rdata_d = cap_shift;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Pad outputs for the coming cycle, decoded from next state so they can be registered.
  always_comb begin
    pin_out_d   = '0;
    pin_oe_d    = '0;
    pin_ale_d   = 1'b0;
    pin_we_d    = 1'b0;
    pin_re_d    = 1'b0;
    rsp_valid_d = 1'b0;
    addr_shamt  = (ADDR_BEATS - 1 - int'(cnt_d)) * PIN_W;
    data_shamt  = (DATA_BEATS - 1 - int'(cnt_d)) * PIN_W;

    unique case (state_d)
      StAddr: begin
        pin_out_d = PIN_W'(addr_d >> addr_shamt);
        pin_oe_d  = '1;
        pin_ale_d = 1'b1;
      end
      StWait: begin
        pin_re_d = !wr_d;
      end
      StData: begin
        if (wr_d) begin
          pin_out_d = PIN_W'(wdata_d >> data_shamt);
          pin_oe_d  = '1;
          pin_we_d  = 1'b1;
        end else begin
          pin_re_d = 1'b1;
        end
      end
      StDone: begin
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      pin_out_q   <= '0;
      pin_oe_q    <= '0;
      pin_ale_q   <= 1'b0;
      pin_we_q    <= 1'b0;
      pin_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      pin_out_q   <= pin_out_d;
      pin_oe_q    <= pin_oe_d;
      pin_ale_q   <= pin_ale_d;
      pin_we_q    <= pin_we_d;
      pin_re_q    <= pin_re_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign pin_out   = pin_out_q;
  assign pin_oe    = pin_oe_q;
  assign pin_ale   = pin_ale_q;
  assign pin_we    = pin_we_q;
  assign pin_re    = pin_re_q;

endmodule

// File: tb/tb_sap_ext_mem_bridge.sv
// Bench for sap_ext_mem_bridge: a default instance (a_*) and a 16-bit data, zero-wait
// instance (b_*). Expected responses are queued at issue and popped by monitors on rsp_valid.
module tb_sap_ext_mem_bridge;

  logic clk;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_busy;
  logic [15:0] a_req_addr;
  logic [7:0]  a_req_wdata, a_rsp_rdata;
  logic [7:0]  a_pin_out, a_pin_oe, a_pin_in;
  logic        a_pin_ale, a_pin_we, a_pin_re;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_busy;
  logic [15:0] b_req_addr;
  logic [15:0] b_req_wdata, b_rsp_rdata;
  logic [7:0]  b_pin_out, b_pin_oe, b_pin_in;
  logic        b_pin_ale, b_pin_we, b_pin_re;

  int n_pass  = 0;
  int n_total = 0;
  int a_rsp_cnt = 0;
  int b_rsp_cnt = 0;
  logic [7:0]  q_a[$];
  logic [15:0] q_b[$];

  sap_ext_mem_bridge dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .busy      (a_busy),
    .pin_out   (a_pin_out),
    .pin_oe    (a_pin_oe),
    .pin_in    (a_pin_in),
    .pin_ale   (a_pin_ale),
    .pin_we    (a_pin_we),
    .pin_re    (a_pin_re)
  );

  sap_ext_mem_bridge #(
    .DATA_W      (16),
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .busy      (b_busy),
    .pin_out   (b_pin_out),
    .pin_oe    (b_pin_oe),
    .pin_in    (b_pin_in),
    .pin_ale   (b_pin_ale),
    .pin_we    (b_pin_we),
    .pin_re    (b_pin_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_a(input string tag, input logic [7:0] out, input logic [7:0] oe,
                       input logic ale, input logic we, input logic re);
    chk({tag, ".pin_out"}, 32'(a_pin_out), 32'(out));
    chk({tag, ".pin_oe"},  32'(a_pin_oe),  32'(oe));
    chk({tag, ".pin_ale"}, 32'(a_pin_ale), 32'(ale));
    chk({tag, ".pin_we"},  32'(a_pin_we),  32'(we));
    chk({tag, ".pin_re"},  32'(a_pin_re),  32'(re));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] out, input logic [7:0] oe,
                       input logic ale, input logic we, input logic re);
    chk({tag, ".pin_out"}, 32'(b_pin_out), 32'(out));
    chk({tag, ".pin_oe"},  32'(b_pin_oe),  32'(oe));
    chk({tag, ".pin_ale"}, 32'(b_pin_ale), 32'(ale));
    chk({tag, ".pin_we"},  32'(b_pin_we),  32'(we));
    chk({tag, ".pin_re"},  32'(b_pin_re),  32'(re));
  endtask

  // Idle/reset picture of instance a.
  task automatic chk_a_idle(input string tag, input logic [7:0] rdata);
    chk_a(tag, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk({tag, ".req_ready"}, 32'(a_req_ready), 32'd1);
    chk({tag, ".busy"},      32'(a_busy),      32'd0);
    chk({tag, ".rsp_valid"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, ".rsp_rdata"}, 32'(a_rsp_rdata), 32'(rdata));
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (a_rsp_valid) begin
      a_rsp_cnt++;
      if (q_a.size() == 0) begin
        n_total++;
        $display("FAIL a_rsp_unexpected: got rsp_valid=1 rdata=0x%0h, expected no response",
                 a_rsp_rdata);
      end else begin
        chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(q_a.pop_front()));
      end
    end
    if (b_rsp_valid) begin
      b_rsp_cnt++;
      if (q_b.size() == 0) begin
        n_total++;
        $display("FAIL b_rsp_unexpected: got rsp_valid=1 rdata=0x%0h, expected no response",
                 b_rsp_rdata);
      end else begin
        chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(q_b.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    rst_n       = 1'b0;
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 16'h12A4;
    a_req_wdata = 8'h5C;
    a_pin_in    = 8'h00;
    b_req_valid = 1'b0;
    b_req_we    = 1'b0;
    b_req_addr  = 16'h0000;
    b_req_wdata = 16'h0000;
    b_pin_in    = 8'h00;

    // Reset held with a pending request.
    repeat (3) begin
      @(negedge clk);
      chk_a_idle("reset", 8'h00);
    end

    // Default write: accepted on the first edge after reset release.
    rst_n = 1'b1;
    q_a.push_back(8'h00);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk_a("wr.c1", 8'h12, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("wr.c1.busy", 32'(a_busy), 32'd1);
    chk("wr.c1.req_ready", 32'(a_req_ready), 32'd0);
    @(negedge clk);
    chk_a("wr.c2", 8'hA4, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("wr.c3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("wr.c4", 8'h5C, 8'hFF, 1'b0, 1'b1, 1'b0);
    chk("wr.c4.rsp_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    chk("wr.c5.rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk_a("wr.c5", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_a_idle("wr.c6", 8'h00);

    // Default read.
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_req_addr  = 16'h00FF;
    q_a.push_back(8'h3E);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_addr  = 16'hDEAD;
    chk_a("rd.c1", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("rd.c2", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("rd.c3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a_pin_in = 8'h3E;
    chk_a("rd.c4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a_pin_in = 8'h00;
    chk("rd.c5.rsp_valid", 32'(a_rsp_valid), 32'd1);
    @(negedge clk);
    chk_a_idle("rd.c6", 8'h3E);
    repeat (2) @(negedge clk);
    chk("rd.hold.rsp_rdata", 32'(a_rsp_rdata), 32'h3E);

    // Wide read on instance b.
    b_req_valid = 1'b1;
    b_req_we    = 1'b0;
    b_req_addr  = 16'h4321;
    q_b.push_back(16'hBEEF);
    @(negedge clk);
    b_req_valid = 1'b0;
    chk_b("wide.c1", 8'h43, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_b("wide.c2", 8'h21, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    b_pin_in = 8'hBE;
    chk_b("wide.c3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("wide.c3.rsp_valid", 32'(b_rsp_valid), 32'd0);
    @(negedge clk);
    b_pin_in = 8'hEF;
    chk_b("wide.c4", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("wide.c4.rsp_valid", 32'(b_rsp_valid), 32'd0);
    @(negedge clk);
    b_pin_in = 8'h00;
    chk("wide.c5.rsp_valid", 32'(b_rsp_valid), 32'd1);
    @(negedge clk);
    chk("wide.c6.req_ready", 32'(b_req_ready), 32'd1);
    chk("wide.c6.rsp_rdata", 32'(b_rsp_rdata), 32'hBEEF);

    // Reset during WAIT of a read: no response may follow.
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_req_addr  = 16'h0ABC;
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_a("abort.c3", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_a_idle("abort.rst", 8'h00);
    @(negedge clk);
    rst_n       = 1'b1;
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 16'h0001;
    a_req_wdata = 8'h77;
    q_a.push_back(8'h00);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk_a("wr2.c1", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("wr2.c2", 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_a("wr2.c4", 8'h77, 8'hFF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("wr2.c5.rsp_valid", 32'(a_rsp_valid), 32'd1);
    @(negedge clk);
    chk_a_idle("wr2.c6", 8'h00);

    // Back-to-back reads with req_valid held high.
    cnt0        = a_rsp_cnt;
    a_req_valid = 1'b1;
    a_req_we    = 1'b0;
    a_req_addr  = 16'h0100;
    q_a.push_back(8'hA1);
    chk("b2b.c0.req_ready", 32'(a_req_ready), 32'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      a_pin_in = (c == 4) ? 8'hA1 : (c == 10) ? 8'h5B : 8'h00;
      if (c <= 5) chk($sformatf("b2b.c%0d.req_ready", c), 32'(a_req_ready), 32'd0);
      if (c == 6) begin
        chk("b2b.c6.req_ready", 32'(a_req_ready), 32'd1);
        q_a.push_back(8'h5B);
      end
      if (c == 7) begin
        a_req_valid = 1'b0;
        chk("b2b.c7.req_ready", 32'(a_req_ready), 32'd0);
      end
    end
    chk("b2b.rsp_pulses", 32'(a_rsp_cnt - cnt0), 32'd2);

    repeat (3) @(negedge clk);
    chk("end.q_a_empty", 32'(q_a.size()), 32'd0);
    chk("end.q_b_empty", 32'(q_b.size()), 32'd0);
    chk("end.a_rsp_total", 32'(a_rsp_cnt), 32'd5);
    chk("end.b_rsp_total", 32'(b_rsp_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
